// File: rtl/exe_stage.sv
// Execute stage of the ARM32 pipeline: val2 generation, ALU, branch target, NZCV and EXE/MEM register.
// Define FORWARD_EN to let sel_src1/sel_src2 select forwarded operands; otherwise they are ignored.
module exe_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        WB_EN_EXE,
  input  logic        MEM_R_EN_EXE,
  input  logic        MEM_W_EN_EXE,
  input  logic        S_EXE,
  input  logic        B_EXE,
  input  logic [3:0]  exe_cmd_EXE,
  input  logic [31:0] pc_EXE,
  input  logic [31:0] rn_val_EXE,
  input  logic [31:0] rm_val_EXE,
  input  logic        imm_EXE,
  input  logic [11:0] shifter_operand_EXE,
  input  logic [23:0] signed_imm_24_EXE,
  input  logic [3:0]  dest_EXE,
  input  logic [3:0]  status_EXE,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] wb_value,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [3:0]  status_reg,
  output logic        WB_EN_MEM,
  output logic        MEM_R_EN_MEM,
  output logic        MEM_W_EN_MEM,
  output logic [31:0] alu_res_MEM,
  output logic [31:0] st_val_MEM,
  output logic [3:0]  dest_MEM
);

  logic [31:0] op1;
  logic [31:0] op2r;
  logic [31:0] val2;
  logic [31:0] imm_val;
  logic [4:0]  imm_amt;
  logic [4:0]  sh_amt;
  logic [31:0] add_b;
  logic        add_cin;
  logic        arith;
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        flag_c;
  logic        flag_v;
  logic        carry_in;
  logic        unused_status;

  assign carry_in      = status_EXE[1];
  assign unused_status = ^{status_EXE[3:2], status_EXE[0]};

`ifdef FORWARD_EN
  always_comb begin
    case (sel_src1)
      2'b01:   op1 = alu_res_MEM;
      2'b10:   op1 = wb_value;
      default: op1 = rn_val_EXE;
    endcase
    case (sel_src2)
      2'b01:   op2r = alu_res_MEM;
      2'b10:   op2r = wb_value;
      default: op2r = rm_val_EXE;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{sel_src1, sel_src2, wb_value};
  assign op1  = rn_val_EXE;
  assign op2r = rm_val_EXE;
`endif

  // A rotate by 0 makes the left-shift term a 32-bit shift, which yields 0, so no special case is needed.
  assign imm_val = {24'b0, shifter_operand_EXE[7:0]};
  assign imm_amt = {shifter_operand_EXE[11:8], 1'b0};
  assign sh_amt  = shifter_operand_EXE[11:7];

  always_comb begin
    if (imm_EXE) begin
      val2 = (imm_val >> imm_amt) | (imm_val << (6'd32 - {1'b0, imm_amt}));
    end else if (MEM_R_EN_EXE || MEM_W_EN_EXE) begin
      val2 = {20'b0, shifter_operand_EXE};
    end else begin
      case (shifter_operand_EXE[6:5])
        2'b00:   val2 = op2r << sh_amt;
        2'b01:   val2 = op2r >> sh_amt;
        2'b10:   val2 = $signed(op2r) >>> sh_amt;
        default: val2 = (op2r >> sh_amt) | (op2r << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

  // Subtraction is folded into the adder as op1 + ~val2 + cin so C reads as "no borrow".
  always_comb begin
    add_b   = val2;
    add_cin = 1'b0;
    arith   = 1'b0;
    case (exe_cmd_EXE)
      4'b0010: arith = 1'b1;
      4'b0011: begin arith = 1'b1; add_cin = carry_in; end
      4'b0100: begin arith = 1'b1; add_b = ~val2; add_cin = 1'b1; end
      4'b0101: begin arith = 1'b1; add_b = ~val2; add_cin = carry_in; end
      default: ;
    endcase
  end

  assign sum = {1'b0, op1} + {1'b0, add_b} + {32'd0, add_cin};

  always_comb begin
    alu_res = '0;
    case (exe_cmd_EXE)
      4'b0001: alu_res = val2;
      4'b1001: alu_res = ~val2;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res = sum[31:0];
      4'b0110: alu_res = op1 & val2;
      4'b0111: alu_res = op1 | val2;
      4'b1000: alu_res = op1 ^ val2;
      default: alu_res = '0;
    endcase
  end

  assign flag_c = arith & sum[32];
  assign flag_v = arith & (op1[31] == add_b[31]) & (sum[31] != op1[31]);

  assign branch_taken   = B_EXE;
  assign branch_address = pc_EXE + {{6{signed_imm_24_EXE[23]}}, signed_imm_24_EXE, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg <= 4'b0;
    end else if (S_EXE && !freeze) begin
      status_reg <= {alu_res[31], (alu_res == 32'd0), flag_c, flag_v};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_EN_MEM    <= 1'b0;
      MEM_R_EN_MEM <= 1'b0;
      MEM_W_EN_MEM <= 1'b0;
      alu_res_MEM  <= 32'd0;
      st_val_MEM   <= 32'd0;
      dest_MEM     <= 4'd0;
    end else if (!freeze) begin
      WB_EN_MEM    <= WB_EN_EXE;
      MEM_R_EN_MEM <= MEM_R_EN_EXE;
      MEM_W_EN_MEM <= MEM_W_EN_EXE;
      alu_res_MEM  <= alu_res;
      st_val_MEM   <= op2r;
      dest_MEM     <= dest_EXE;
    end
  end

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage ARM32 pipeline. It sits directly downstream of the ID/EXE pipeline register and consumes its outputs. It generates the second operand (val2), runs the ALU, computes the branch target, and owns the NZCV status register that feeds condition checking in ID. It also contains the EXE/MEM pipeline register, which freezes during cache stalls.

## Interface
Parameters: none.

Clock and reset:
- clk  in  1  pipeline clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset

Control:
- freeze  in  1  cache stall; holds the status register and EXE/MEM register

Inputs from ID/EXE:
- WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE, S_EXE, B_EXE  in  1 each  control bits
- exe_cmd_EXE  in  4  ALU op
- pc_EXE  in  32  instruction address + 4
- rn_val_EXE, rm_val_EXE  in  32  register operands
- imm_EXE  in  1  immediate operand select
- shifter_operand_EXE  in  12  shifter operand / memory offset
- signed_imm_24_EXE  in  24  branch offset
- dest_EXE  in  4  destination register
- status_EXE  in  4  NZCV captured at decode; its C bit is the ADC/SBC carry-in

Forwarding inputs:
- sel_src1, sel_src2  in  2  00 register value, 01 alu_res_MEM, 10 wb_value
- wb_value  in  32  write-back value

Outputs:
- branch_taken  out  1  equals B_EXE
- branch_address  out  32  branch target
- status_reg  out  4  NZCV to ID
- WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM  out  1 each  registered control bits
- alu_res_MEM  out  32  registered ALU result
- st_val_MEM  out  32  registered store data (forwarded rm)
- dest_MEM  out  4  registered destination

## Operation
- Operands: op1 = fwd(rn_val_EXE, sel_src1); op2r = fwd(rm_val_EXE, sel_src2). Select value 11 behaves as 00.
- Val2 selection, first match wins:
  - imm_EXE=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - else MEM_R_EN_EXE or MEM_W_EN_EXE: zero-extended so[11:0].
  - else op2r shifted by so[11:7] with type so[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 passes op2r unchanged.
- ALU, by exe_cmd:
  - 0001 MOV: val2
  - 1001 MVN: ~val2
  - 0010 ADD/LDR/STR: op1+val2
  - 0011 ADC: op1+val2+C
  - 0100 SUB/CMP: op1-val2
  - 0101 SBC: op1-val2-!C
  - 0110 AND/TST: op1&val2
  - 0111 ORR: op1|val2
  - 1000 EOR: op1^val2
  - other: result 0
- Flags:
  - N = res[31]; Z = (res==0).
  - Arithmetic ops use a 33-bit sum. C = bit 32, with subtraction done as op1 + ~val2 + carry, so C=1 means no borrow.
  - V = signed overflow of that add.
  - Logic, MOV and MVN set C=V=0.
- Status register: loads {N,Z,C,V} when S_EXE & ~freeze. Otherwise it holds.
- Branch: branch_address = pc_EXE + {{6{imm24[23]}}, imm24, 2'b00}, computed combinationally every cycle.
- EXE/MEM register: loads the control bits, ALU result, op2r and dest_EXE when ~freeze. Otherwise it holds.

## Timing
- Reset (posedge clk with rst=1): status_reg and every *_MEM output go to 0. Reset takes priority over freeze.
- branch_taken and branch_address are combinational, valid the same cycle as the ID/EXE outputs.
- Latency to alu_res_MEM and the other *_MEM outputs: 1 cycle.
- Latency to status_reg: 1 cycle after the S instruction sits in EXE.
- Freeze and S_EXE asserted together: no status update. The instruction is re-presented while frozen, so the update happens on the unfrozen edge.
- Multi-cycle freeze: all registered outputs stay stable for every frozen cycle.
- Reset deasserted mid-stream: the first instruction presented after reset behaves normally, and ADC/SBC use status_EXE as given.

## Configuration
- FORWARD_EN defined: sel_src1 and sel_src2 drive the operand muxes as described above.
- FORWARD_EN undefined: sel_src1, sel_src2 and wb_value are ignored; op1 = rn_val_EXE and op2r = rm_val_EXE. The hazard unit then stalls instead of forwarding. The ports remain present.

## Test plan
- ADD with S=1: rn=0x7FFFFFFF, imm=1, so=0x001 -> alu_res_MEM=0x80000000 next cycle; status_reg=1001 (N,V).
- SUB/CMP: rn=5, rm=5, register shift LSL #0 -> result 0; status_reg=0110 (Z,C).
- Immediate rotate: so=0x4FF -> val2=0xFF000000; MOV gives alu_res_MEM=0xFF000000. Register ASR: rm=0x80000000, so=0x0C0 (ASR #1) -> 0xC0000000.
- Branch: pc=0x100, imm24=0xFFFFFE -> branch_address=0xF8, branch_taken=1 in the same cycle.
- Freeze: hold freeze high for 3 cycles with S=1 ADD presented -> *_MEM and status_reg unchanged; both update on the first unfrozen edge. rst pulsed during freeze -> all outputs 0.
- FORWARD_EN defined: sel_src1=01, alu_res_MEM=0x10, rn=0, ADD imm 1 -> result 0x11. Without FORWARD_EN -> result 0x1.
